// File: rtl/n101_pad_output_shaper.sv
// Pad output shaper: drives a pad from a flop so that every level is held for
// at least MIN_HOLD cycles, with level-follow and one-shot pulse modes.
module n101_pad_output_shaper #(
  parameter int unsigned MIN_HOLD = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_d,
  input  logic             io_mode,
  input  logic             io_pulse_req,
  input  logic [CNT_W-1:0] io_pulse_len,
  output logic             io_q,
  output logic             io_busy,
  output logic             io_ack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_PULSE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MIN  = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             q_nx;
  logic             busy_nx;
  logic             ack_nx;
  logic             target;
  logic [CNT_W-1:0] pulse_len_eff;

  // State, counter and all outputs are flops; reset clears the pad asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      io_q    <= 1'b0;
      io_busy <= 1'b0;
      io_ack  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      io_q    <= q_nx;
      io_busy <= busy_nx;
      io_ack  <= ack_nx;
    end
  end

  // Next-state logic; busy and ack are derived from the next state so they line
  // up with the cycle they describe.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    q_nx          = io_q;
    target        = io_mode ? 1'b0 : io_d;
    pulse_len_eff = (io_pulse_len >= HOLD_MIN) ? io_pulse_len : HOLD_MIN;

    case (state)
      S_IDLE: begin
        // A pending level change wins over a pulse request.
        if (target != io_q) begin
          q_nx     = target;
          state_nx = S_HOLD;
          cnt_nx   = HOLD_LAST;
        end else if (io_mode && io_pulse_req && !io_q) begin
          q_nx     = 1'b1;
          state_nx = S_PULSE;
          cnt_nx   = pulse_len_eff - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          q_nx     = 1'b0;
          state_nx = S_GAP;
          cnt_nx   = HOLD_LAST;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        q_nx     = 1'b0;
      end
    endcase

    busy_nx = (state_nx != S_IDLE);
    ack_nx  = (state_nx == S_GAP) && (cnt_nx == '0);
  end

endmodule
